// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the 7-segment scan controller: segment patterns, anode mask, FSM encoding.
// Pure declarations; no logic, no latency, no flow control.
package seg_pkg;

  localparam int MAX_DIGITS = 8;

  // Segments are active-low {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  // Anodes are active-low; slice to the configured digit count.
  localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bundle between the status-register side and the display pins of seg_scan_ctrl.
// master drives en/load/value and observes the display; slave is the controller.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [6:0]              segs;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_tick;

  modport master (
    output en, load, value,
    input  segs, an, frame_tick
  );

  modport slave (
    input  en, load, value,
    output segs, an, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Registered hex to active-low 7-segment decoder, one cycle latency, no flow control.
// Reset shows a dash so an unloaded display is visibly distinct from zero.
module hex7seg
  import seg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hex,
  output logic [6:0] segs
);

  always_ff @(posedge clk) begin
    if (reset) begin
      segs <= SEG_DASH;
    end else begin
      case (hex)
        4'h0:    segs <= SEG_ZERO;
        4'h1:    segs <= 7'b1111001;
        4'h2:    segs <= 7'b0100100;
        4'h3:    segs <= 7'b0110000;
        4'h4:    segs <= 7'b0011001;
        4'h5:    segs <= 7'b0010010;
        4'h6:    segs <= 7'b0000010;
        4'h7:    segs <= 7'b1111000;
        4'h8:    segs <= 7'b0000000;
        4'h9:    segs <= 7'b0010000;
        4'hA:    segs <= 7'b0001000;
        4'hB:    segs <= 7'b0000011;
        4'hC:    segs <= 7'b1000110;
        4'hD:    segs <= 7'b0100001;
        4'hE:    segs <= 7'b0000110;
        default: segs <= 7'b0001110;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scans NUM_DIGITS common-anode digits through one registered decoder with blank/dwell slots; loads are frame-atomic.
// Outputs registered, no input-to-output path; SEG_SCAN_LZ_BLANK_EN enables leading-zero suppression.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input logic           clk,
  input logic           reset,
  seg_scan_ctrl_if.slave bus
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int IW      = $clog2(NUM_DIGITS) + 1;
  localparam int VW      = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  state_t                state, nxt_state;
  logic [CW-1:0]         cnt, nxt_cnt;
  logic [IW-1:0]         idx, nxt_idx;
  logic [NUM_DIGITS-1:0] an_q, an_nxt;
  logic                  ft_q, ft_nxt;

  logic [VW-1:0]         stage, shadow;
  logic                  pend;
  logic                  apply;

  logic [3:0]            nib;
  logic [NUM_DIGITS-1:0] dark;

  // Digit i is dark when it and every higher nibble are zero; digit 0 never goes dark.
`ifdef SEG_SCAN_LZ_BLANK_EN
  always_comb begin
    logic acc;
    acc  = 1'b1;
    dark = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc     = acc & (shadow[4*i +: 4] == 4'h0);
      dark[i] = acc & (i != 0);
    end
  end
`else
  assign dark = '0;
`endif

  always_comb begin
    nib = shadow[3:0];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) nib = shadow[4*i +: 4];
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + CW'(1);
    nxt_idx   = idx;
    if (!bus.en) begin
      nxt_state = ST_BLANK;
      nxt_cnt   = '0;
      nxt_idx   = '0;
    end else begin
      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            nxt_state = ST_SHOW;
            nxt_cnt   = '0;
          end
        end
        ST_SHOW: begin
          if (cnt == DWELL_LAST) begin
            nxt_state = ST_BLANK;
            nxt_cnt   = '0;
            nxt_idx   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
          end
        end
        default: begin
          nxt_state = ST_BLANK;
          nxt_cnt   = '0;
          nxt_idx   = '0;
        end
      endcase
    end

    an_nxt = AN_OFF[NUM_DIGITS-1:0];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (nxt_state == ST_SHOW && nxt_idx == IW'(i) && !dark[i]) an_nxt[i] = 1'b0;
    end

    // Registered tick lands on the final dwell cycle of the last digit.
    ft_nxt = (nxt_state == ST_SHOW) && (nxt_cnt == DWELL_LAST) && (nxt_idx == IDX_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_BLANK;
      cnt   <= '0;
      idx   <= '0;
      an_q  <= AN_OFF[NUM_DIGITS-1:0];
      ft_q  <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      idx   <= nxt_idx;
      an_q  <= an_nxt;
      ft_q  <= ft_nxt;
    end
  end

  // Shadow only changes at a frame boundary or while dark, so no frame mixes old and new digits.
  assign apply = ft_q | ~bus.en;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage  <= '0;
      shadow <= '0;
      pend   <= 1'b0;
    end else if (bus.load && apply) begin
      stage  <= bus.value;
      shadow <= bus.value;
      pend   <= 1'b0;
    end else if (bus.load) begin
      stage  <= bus.value;
      pend   <= 1'b1;
    end else if (apply && pend) begin
      shadow <= stage;
      pend   <= 1'b0;
    end
  end

  hex7seg u_dec (
    .clk   (clk),
    .reset (reset),
    .hex   (nib),
    .segs  (bus.segs)
  );

  assign bus.an         = an_q;
  assign bus.frame_tick = ft_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: 4-digit scan (dwell 4, blank 2) plus a 1-digit instance (dwell 1, blank 1).
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

`ifdef SEG_SCAN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();
  seg_scan_ctrl_if #(.NUM_DIGITS(1)) bus1 ();

  seg_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  seg_scan_ctrl #(.NUM_DIGITS(1), .DWELL_CYCLES(1), .BLANK_CYCLES(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_tick && n < 200);
    chk("tick_seen", bus.frame_tick, 1);
  endtask

  // Entered on a frame_tick cycle; checks one full 24-cycle frame, optionally pulsing load at frame cycles lc1/lc2.
  task automatic check_frame(input logic [15:0] v, input int lc1, input logic [15:0] lv1,
                             input int lc2, input logic [15:0] lv2);
    int k;
    k = 0;
    for (int d = 0; d < 4; d++) begin
      logic [3:0]  nb;
      logic        lit;
      logic [3:0]  an_exp;
      logic [15:0] hi;
      nb     = v[4*d +: 4];
      hi     = v >> (4 * d);
      lit    = !(LZ && d > 0 && hi == 16'h0);
      an_exp = lit ? ~(4'b0001 << d) : 4'b1111;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (c < 2) begin
          chk("blank_an", bus.an, 4'hF);
        end else begin
          chk("show_an", bus.an, an_exp);
          if (lit) chk("show_segs", bus.segs, seg_of(nb));
        end
        chk("frame_tick", bus.frame_tick, (d == 3 && c == 5));
        bus.load = (k == lc1) || (k == lc2);
        if (k == lc1) bus.value = lv1;
        if (k == lc2) bus.value = lv2;
        k++;
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.en    = 1'b1;
    bus.load  = 1'b0;
    bus.value = '0;
    bus1.en   = 1'b1;
    bus1.load = 1'b0;
    bus1.value = '0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_an", bus.an, 4'hF);
      chk("rst_segs", bus.segs, 7'b0111111);
      chk("rst_ft", bus.frame_tick, 0);
    end
    reset = 1'b0;

    // Main instance lights digit 0 two cycles after release; the 1-digit instance alternates every cycle.
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("n1_an", bus1.an, (k % 2 == 1) ? 1'b0 : 1'b1);
      chk("n1_ft", bus1.frame_tick, (k % 2 == 1));
      if (k == 3) chk("n1_segs", bus1.segs, 7'b1000000);
      if (k == 1) chk("rel_an1", bus.an, 4'hF);
      if (k == 2) chk("rel_an2", bus.an, 4'hE);
    end

    bus.load  = 1'b1;
    bus.value = 16'h12AF;
    @(negedge clk);
    bus.load = 1'b0;
    wait_tick();
    check_frame(16'h12AF, -1, 16'h0, -1, 16'h0);

    // Mid-frame load defers to the next frame; two loads in one frame, last wins.
    check_frame(16'h12AF, 8, 16'h0000, -1, 16'h0);
    check_frame(16'h0000, 3, 16'h1111, 15, 16'h2222);
    check_frame(16'h2222, -1, 16'h0, -1, 16'h0);

    // Load on the tick cycle goes straight to the next frame.
    bus.load  = 1'b1;
    bus.value = 16'hABCD;
    check_frame(16'hABCD, -1, 16'h0, -1, 16'h0);

    repeat (9) @(negedge clk);
    chk("pre_dis_an", bus.an, 4'hD);
    bus.en = 1'b0;
    @(negedge clk);
    chk("dis_an", bus.an, 4'hF);
    chk("dis_ft", bus.frame_tick, 0);
    bus.load  = 1'b1;
    bus.value = 16'h5678;
    @(negedge clk);
    bus.load = 1'b0;
    chk("dis_an2", bus.an, 4'hF);
    repeat (2) @(negedge clk);
    chk("dis_an3", bus.an, 4'hF);
    bus.en = 1'b1;
    @(negedge clk);
    chk("ren_an1", bus.an, 4'hF);
    @(negedge clk);
    chk("ren_an2", bus.an, 4'hE);
    chk("ren_segs", bus.segs, 7'b0000000);
    wait_tick();
    check_frame(16'h5678, -1, 16'h0, -1, 16'h0);

    bus.load  = 1'b1;
    bus.value = 16'h0070;
    check_frame(16'h0070, -1, 16'h0, -1, 16'h0);
    bus.load  = 1'b1;
    bus.value = 16'h0000;
    check_frame(16'h0000, -1, 16'h0, -1, 16'h0);

    // Reset discards a pending load.
    bus.load  = 1'b1;
    bus.value = 16'h0000;
    check_frame(16'h0000, 4, 16'h9999, -1, 16'h0);
    repeat (5) @(negedge clk);
    bus.load  = 1'b1;
    bus.value = 16'h9999;
    @(negedge clk);
    bus.load = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_an", bus.an, 4'hF);
    chk("mid_rst_segs", bus.segs, 7'b0111111);
    wait_tick();
    check_frame(16'h0000, -1, 16'h0, -1, 16'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
